// File: rtl/ternary_unpacker.sv
// ternary_unpacker: decodes base-3 packed bytes (5 trits/byte) into a 12-trit FIFO and emits 4 weights per pop.
module ternary_unpacker #(
  parameter int BUF_TRITS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_zero,
  output logic [3:0] out_sign,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_illegal
);
  logic [BUF_TRITS-1:0] z_q, z_d, s_q, s_d, zs, ss;
  logic [3:0] cnt_q, cnt_d, base;
  logic       err_q, err_d, acc, pop, bad;
  logic [4:0] dz, ds;
  logic [7:0] v;
  assign in_ready    = cnt_q <= 4'd7;
  assign out_valid   = cnt_q >= 4'd4;
  assign out_zero    = out_valid ? z_q[3:0] : 4'b1111;
  assign out_sign    = out_valid ? s_q[3:0] : 4'b0000;
  assign err_illegal = err_q;
  assign acc         = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready & ~flush;
  assign bad         = in_data > 8'd242;
  always_comb begin
    v = in_data;
    for (int i = 0; i < 5; i++) begin
      dz[i] = bad | (v % 8'd3 == 8'd0);
      ds[i] = ~bad & (v % 8'd3 == 8'd2);
      v = v / 8'd3;
    end
  end
  // Pop shifts the 4 oldest out first, so new trits append behind what remains.
  always_comb begin
    zs   = pop ? z_q >> 4 : z_q;
    ss   = pop ? s_q >> 4 : s_q;
    base = pop ? cnt_q - 4'd4 : cnt_q;
    z_d  = zs;
    s_d  = ss;
    if (acc)
      for (int j = 0; j < 5; j++) begin
        z_d[base + 4'(j)] = dz[j];
        s_d[base + 4'(j)] = ds[j];
      end
    cnt_d = flush ? 4'd0 : base + (acc ? 4'd5 : 4'd0);
    err_d = ~flush & (err_q | (acc & bad));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    z_q <= z_d;
    s_q <= s_d;
  end
endmodule

// File: tb/tb_ternary_unpacker.sv
// tb_ternary_unpacker: random and directed stimulus checked against a queue-based trit model.
module tb_ternary_unpacker;
  logic       clk = 0, reset, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, err_illegal;
  logic [3:0] out_zero, out_sign;
  int total = 0, bad = 0;
  bit started = 0;
  int q[$];
  bit err_m;
  ternary_unpacker dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_zero(out_zero), .out_sign(out_sign), .out_valid(out_valid),
    .out_ready(out_ready), .err_illegal(err_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: queue of digits 0/1/2, oldest at front.
  always @(posedge clk) begin
    bit a, p;
    int b;
    if (reset || flush) begin
      q.delete();
      err_m = 0;
    end else begin
      a = in_valid && q.size() <= 7;
      p = out_ready && q.size() >= 4;
      if (p) repeat (4) void'(q.pop_front());
      if (a) begin
        b = in_data;
        if (b > 242) begin
          err_m = 1;
          repeat (5) q.push_back(0);
        end else
          for (int k = 0; k < 5; k++) begin
            q.push_back(b % 3);
            b = b / 3;
          end
      end
    end
  end
  always @(negedge clk) if (started) begin
    int ez, es;
    ez = 15; es = 0;
    if (q.size() >= 4) begin
      ez = 0;
      for (int k = 0; k < 4; k++) begin
        if (q[k] == 0) ez |= 1 << k;
        if (q[k] == 2) es |= 1 << k;
      end
    end
    chk("in_ready", in_ready, q.size() <= 7);
    chk("out_valid", out_valid, q.size() >= 4);
    chk("out_zero", out_zero, ez);
    chk("out_sign", out_sign, es);
    chk("err_illegal", err_illegal, err_m);
    chk("count_bound", q.size() <= 12, 1);
  end
  task automatic set(input bit r, input bit f, input bit v, input logic [7:0] d, input bit o);
    reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
  endtask
  task automatic nx;
    @(negedge clk);
  endtask
  initial begin
    int lows;
    set(1, 0, 0, 0, 0);
    nx; nx;
    started = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", out_zero, 4'b1111);
    chk("rst_sign", out_sign, 4'b0000);
    chk("rst_err", err_illegal, 0);
    set(0, 0, 1, 8'h05, 0); nx;
    chk("b05_valid", out_valid, 1);
    chk("b05_zero", out_zero, 4'b1100);
    chk("b05_sign", out_sign, 4'b0001);
    chk("b05_ready", in_ready, 1);
    set(0, 0, 1, 8'hF2, 0); nx;
    chk("f2_ready_low", in_ready, 0);
    set(0, 0, 0, 0, 1);
    chk("pop1_zero", out_zero, 4'b1100);
    chk("pop1_sign", out_sign, 4'b0001);
    nx;
    chk("pop2_zero", out_zero, 4'b0001);
    chk("pop2_sign", out_sign, 4'b1110);
    nx;
    chk("pop_done_valid", out_valid, 0);
    set(0, 0, 1, 8'h05, 0); nx;
    chk("pre_flush_valid", out_valid, 1);
    chk("pre_flush_ready", in_ready, 1);
    set(0, 1, 1, 8'h79, 1); nx;
    chk("flush_valid", out_valid, 0);
    chk("flush_zero", out_zero, 4'b1111);
    set(0, 0, 1, 8'hFA, 0); nx;
    chk("fa_err", err_illegal, 1);
    chk("fa_zero", out_zero, 4'b1111);
    chk("fa_valid", out_valid, 1);
    set(0, 1, 0, 0, 0); nx;
    chk("fa_flush_err", err_illegal, 0);
    chk("fa_flush_valid", out_valid, 0);
    set(0, 0, 1, 8'h79, 1);
    repeat (5) nx;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      nx;
      chk("stream_valid", out_valid, 1);
      chk("stream_zero", out_zero, 0);
      if (!in_ready) lows++;
    end
    chk("stream_ready_lows", lows, 8);
    set(0, 0, 1, 8'h37, 0);
    repeat (6) nx;
    chk("bp_ready", in_ready, 0);
    set(0, 0, 0, 0, 1);
    repeat (6) nx;
    for (int i = 0; i < 3000; i++) begin
      set($urandom_range(99) == 0, $urandom_range(60) == 0, $urandom_range(3) != 0,
          8'($urandom_range(255)), $urandom_range(3) != 0);
      nx;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
